event_encoder8to3: RTL

Sequential priority encoder: the encoding counterpart to the team's 2-to-4 / 3-to-8 decoders. It captures rising edges on N request lines into a pending register. It presents the highest-priority pending line as a binary code with a valid/ready handshake, and clears that line's pending bit on acceptance. It sits between raw event/interrupt lines and a consumer that expects one encoded event at a time.

---
 rtl/event_enc_pkg.sv | 8 +
 rtl/event_encoder8to3_prio_enc.sv | 16 +
 rtl/event_encoder8to3.sv | 74 +++++++
 3 files changed

// File: rtl/event_enc_pkg.sv
// event_enc_pkg: shared types and constants for the event encoder (EVENT_ENCODER_LOST_EN adds the lost counter)
package event_enc_pkg;
  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_PRESENT = 1'b1} state_t;
  localparam int LOST_CNT_W = 8;
  localparam logic [LOST_CNT_W-1:0] LOST_CNT_MAX = 8'd255;
  localparam int DEF_N = 8;
  localparam int DEF_CODE_W = $clog2(DEF_N);
endpackage

// File: rtl/event_encoder8to3_prio_enc.sv
// prio_enc: combinational MSB-first priority encoder with an any-set flag
module prio_enc #(
  parameter int N = 8,
  localparam int CODE_W = $clog2(N)
) (
  input  logic [N-1:0]      vec,
  output logic [CODE_W-1:0] code,
  output logic              any
);
  // ascending scan so the highest set index is the last one written
  always_comb begin
    code = '0;
    for (int i = 0; i < N; i++) code = vec[i] ? CODE_W'(i) : code;
  end
  assign any = |vec;
endmodule

// File: rtl/event_encoder8to3.sv
// event_encoder8to3: captures request rising edges and hands out the highest pending index over valid/ready (EVENT_ENCODER_LOST_EN adds lost_cnt/lost_clr)
module event_encoder8to3
  import event_enc_pkg::*;
#(
  parameter int N = DEF_N,
  localparam int CODE_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [N-1:0]      req,
`ifdef EVENT_ENCODER_LOST_EN
  input  logic              lost_clr,
  output logic [LOST_CNT_W-1:0] lost_cnt,
`endif
  input  logic              ready,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  output logic [N-1:0]      pending
);
  state_t              state;
  logic [N-1:0]        req_q;
  logic [N-1:0]        rise;
  logic [N-1:0]        clr;
  logic [CODE_W-1:0]   enc;
  logic                any;
  logic                hs;

  assign rise  = en ? req & ~req_q : '0;
  assign valid = state == ST_PRESENT;
  assign hs    = valid & ready;
  assign clr   = hs ? N'(1) << code : '0;

  prio_enc #(.N(N)) u_prio (.vec(pending), .code(enc), .any(any));

  // edge history and pending set/clear; a new rise beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= '0;
      pending <= '0;
    end else begin
      req_q   <= req;
      pending <= (pending & ~clr) | rise;
    end
  end

  // code is latched once in IDLE and held until the consumer takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      code  <= '0;
    end else if (state == ST_IDLE) begin
      if (any) begin
        state <= ST_PRESENT;
        code  <= enc;
      end
    end else if (ready) begin
      state <= ST_IDLE;
    end
  end

`ifdef EVENT_ENCODER_LOST_EN
  logic [N-1:0]          lost;
  logic [LOST_CNT_W:0]   lost_sum;
  assign lost     = rise & pending & ~clr;
  assign lost_sum = {1'b0, lost_cnt} + (LOST_CNT_W + 1)'($countones(lost));
  // saturating count of rises merged into an already pending bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lost_cnt <= '0;
    else if (lost_clr) lost_cnt <= '0;
    else lost_cnt <= lost_sum > {1'b0, LOST_CNT_MAX} ? LOST_CNT_MAX : lost_sum[LOST_CNT_W-1:0];
  end
`endif
endmodule
